// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing the GPIO register-bank slave between CPU (m0) and pixel sequencer (m1), with lock tenures.
// Latency: request/grant/response are combinational passthroughs; backpressure: the losing master holds req until granted.
module gpio_bus_arbiter #(
  parameter int unsigned LOCK_MAX     = 4,
  parameter int unsigned HOLD_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  output logic        busy
);

  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);
  localparam logic [7:0] HOLD_C     = 8'(HOLD_TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_RSP, LOCK_HOLD} state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       prio_last_q, prio_last_d;
  logic       lock_q, lock_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       busy_q, busy_d;

  bus_req_t m0_f, m1_f, sel_f;
  logic     winner, sel_mst, active, sel_req, sel_lock, hs, rsp_ok;
  logic [7:0] hold_inc;

  assign m0_f = {m0_we, m0_be, m0_addr, m0_wdata};
  assign m1_f = {m1_we, m1_be, m1_addr, m1_wdata};

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    prio_last_d = prio_last_q;
    lock_d      = lock_q;
    lock_cnt_d  = lock_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    hold_inc    = hold_cnt_q + 8'd1;

    // On a tie the master that did not win last time goes first.
    winner  = (m0_req & m1_req) ? ~prio_last_q : m1_req;
    sel_mst = 1'b0;
    active  = 1'b0;
    case (state_q)
      IDLE:      begin sel_mst = winner;  active = 1'b1; end
      LOCK_HOLD: begin sel_mst = owner_q; active = 1'b1; end
      default:   ;
    endcase
    sel_req  = active & ~rst & (sel_mst ? m1_req : m0_req);
    sel_lock = sel_mst ? m1_lock : m0_lock;
    hs       = sel_req & s_gnt;

    case (state_q)
      IDLE: begin
        if (hs) begin
          owner_d     = sel_mst;
          prio_last_d = sel_mst;
          lock_d      = sel_lock;
          lock_cnt_d  = 4'd1;
          state_d     = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (s_rvalid) begin
          if (lock_q && (lock_cnt_q < LOCK_MAX_C)) begin
            state_d    = LOCK_HOLD;
            hold_cnt_d = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LOCK_HOLD: begin
        if (hs) begin
          lock_d     = sel_lock;
          lock_cnt_d = (lock_cnt_q == 4'hF) ? lock_cnt_q : lock_cnt_q + 4'd1;
          state_d    = WAIT_RSP;
        end else if (!sel_req) begin
          if (!sel_lock) begin
            state_d = IDLE;
          end else begin
            // Owner keeps lock but stops issuing: release after the idle budget.
            hold_cnt_d = hold_inc;
            if (hold_inc == HOLD_C) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      prio_last_q <= 1'b1;
      lock_q      <= 1'b0;
      lock_cnt_q  <= 4'd0;
      hold_cnt_q  <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      prio_last_q <= prio_last_d;
      lock_q      <= lock_d;
      lock_cnt_q  <= lock_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign sel_f = sel_mst ? m1_f : m0_f;
  assign s_req = sel_req;
  assign {s_we, s_be, s_addr, s_wdata} = sel_req ? sel_f : '0;
  assign m0_gnt = hs & ~sel_mst;
  assign m1_gnt = hs & sel_mst;

  // Responses only count while a transaction is outstanding; stray ones are dropped.
  assign rsp_ok    = (state_q == WAIT_RSP) & ~rst;
  assign m0_rvalid = rsp_ok & s_rvalid & ~owner_q;
  assign m1_rvalid = rsp_ok & s_rvalid & owner_q;
  assign m0_rdata  = (rsp_ok & ~owner_q) ? s_rdata : '0;
  assign m1_rdata  = (rsp_ok & owner_q) ? s_rdata : '0;
  assign busy      = busy_q & ~rst;

endmodule
